// File: rtl/duart_bus_pkg.sv
// rtl/duart_bus_pkg.sv - shared types and constants for the DUART bus master (DUART_DTACK_EN widens the counter)
package duart_bus_pkg;

`ifdef DUART_DTACK_EN
    localparam int CNT_W = 8;
`else
    localparam int CNT_W = 4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    localparam logic [3:0] REG_MRA        = 4'd0;
    localparam logic [3:0] REG_SRA_CSRA   = 4'd1;
    localparam logic [3:0] REG_CRA        = 4'd2;
    localparam logic [3:0] REG_RBA_TBA    = 4'd3;
    localparam logic [3:0] REG_ACR        = 4'd4;
    localparam logic [3:0] REG_ISR_IMR    = 4'd5;
    localparam logic [3:0] REG_CTU        = 4'd6;
    localparam logic [3:0] REG_CTL        = 4'd7;
    localparam logic [3:0] REG_MRB        = 4'd8;
    localparam logic [3:0] REG_SRB_CSRB   = 4'd9;
    localparam logic [3:0] REG_CRB        = 4'd10;
    localparam logic [3:0] REG_RBB_TBB    = 4'd11;
    localparam logic [3:0] REG_IVR        = 4'd12;
    localparam logic [3:0] REG_IP_OPCR    = 4'd13;
    localparam logic [3:0] REG_SCC_SOPBC  = 4'd14;
    localparam logic [3:0] REG_STC_ROPBC  = 4'd15;

    // Phase counter counts down to zero, so a phase of n cycles loads n-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/duart_bus_master_if.sv
// rtl/duart_bus_master_if.sv - request/response and DUART register-bus signals (DUART_DTACK_EN adds dtack_n)
interface duart_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [3:0] a;
    logic       r_w;
    logic       cs;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       int_n;
    logic       int_pend;
`ifdef DUART_DTACK_EN
    logic       dtack_n;
`endif

    modport master (
        input  req_valid, req_rnw, req_addr, req_wdata, data_in, int_n,
`ifdef DUART_DTACK_EN
        input  dtack_n,
`endif
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output a, r_w, cs, data_out, data_oe, int_pend
    );

    modport slave (
        output req_valid, req_rnw, req_addr, req_wdata, data_in, int_n,
`ifdef DUART_DTACK_EN
        output dtack_n,
`endif
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  a, r_w, cs, data_out, data_oe, int_pend
    );
endinterface

// File: rtl/duart_sync2.sv
// rtl/duart_sync2.sv - two-flop synchroniser for active-low DUART strobes, resets to 1 (inactive)
module duart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/duart_bus_master.sv
// rtl/duart_bus_master.sv - MC68681 register-bus initiator; DUART_DTACK_EN enables DTACK-extended strobes
module duart_bus_master
    import duart_bus_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
`ifdef DUART_DTACK_EN
   ,parameter int TIMEOUT_CYC = 64
`endif
) (
    input logic                clk,
    input logic                rst_n,
    duart_bus_master_if.master bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             int_s;
    logic             strobe_end;
    logic             end_err;

    duart_sync2 u_int_sync (.clk(clk), .rst_n(rst_n), .d(bus.int_n), .q(int_s));
    assign bus.int_pend = ~int_s;

`ifdef DUART_DTACK_EN
    logic dtack_s;
    logic waiting;

    duart_sync2 u_dtack_sync (.clk(clk), .rst_n(rst_n), .d(bus.dtack_n), .q(dtack_s));

    // After the minimum strobe, keep CS low until DTACK is seen or the timeout phase runs out.
    always_comb begin
        strobe_end = 1'b0;
        end_err    = 1'b0;
        if (state == ST_STROBE) begin
            if (!dtack_s && (cnt == '0 || waiting)) begin
                strobe_end = 1'b1;
            end else if (cnt == '0 && waiting) begin
                strobe_end = 1'b1;
                end_err    = 1'b1;
            end
        end
    end
`else
    assign strobe_end  = (state == ST_STROBE) && (cnt == '0);
    assign end_err     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 8'h00;
            bus.a         <= 4'h0;
            bus.r_w       <= 1'b1;
            bus.cs        <= 1'b1;
            bus.data_out  <= 8'h00;
            bus.data_oe   <= 1'b0;
`ifdef DUART_DTACK_EN
            waiting       <= 1'b0;
            bus.rsp_err   <= 1'b0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        state         <= ST_SETUP;
                        cnt           <= cnt_load(SETUP_CYC);
                        bus.a         <= bus.req_addr;
                        bus.r_w       <= bus.req_rnw;
                        bus.data_oe   <= ~bus.req_rnw;
                        bus.data_out  <= bus.req_wdata;
                        bus.cs        <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state  <= ST_STROBE;
                        cnt    <= cnt_load(STROBE_CYC);
                        bus.cs <= 1'b0;
`ifdef DUART_DTACK_EN
                        waiting <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (strobe_end) begin
                        bus.cs        <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        if (end_err)
                            bus.rsp_rdata <= 8'hFF;
                        else if (bus.r_w)
                            bus.rsp_rdata <= bus.data_in;
`ifdef DUART_DTACK_EN
                        bus.rsp_err <= end_err;
`endif
                        if (HOLD_CYC > 0) begin
                            state <= ST_HOLD;
                            cnt   <= cnt_load(HOLD_CYC);
                        end else if (RECOVER_CYC > 0) begin
                            state       <= ST_RECOVER;
                            cnt         <= cnt_load(RECOVER_CYC);
                            bus.r_w     <= 1'b1;
                            bus.data_oe <= 1'b0;
                        end else begin
                            state         <= ST_IDLE;
                            bus.r_w       <= 1'b1;
                            bus.data_oe   <= 1'b0;
                            bus.req_ready <= 1'b1;
                        end
                    end
`ifdef DUART_DTACK_EN
                    else if (cnt == '0) begin
                        waiting <= 1'b1;
                        cnt     <= cnt_load(TIMEOUT_CYC);
                    end
`endif
                    else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        bus.r_w     <= 1'b1;
                        bus.data_oe <= 1'b0;
                        if (RECOVER_CYC > 0) begin
                            state <= ST_RECOVER;
                            cnt   <= cnt_load(RECOVER_CYC);
                        end else begin
                            state         <= ST_IDLE;
                            bus.req_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    // Ready is raised on entry so IDLE costs exactly one cycle back-to-back.
                    if (cnt == '0) begin
                        state         <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
